// File: rtl/shifter_arbiter.sv
// Two-requester round-robin front end for a shared 8-op, 8-bit shift datapath.
// Results go through a single registered stage. Each requester has a saturating completion counter.
module shifter_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_sel,
    input  logic [7:0]       req0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_sel,
    input  logic [7:0]       req1_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_id,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    function automatic logic [7:0] shift_op(input logic [2:0] sel, input logic [7:0] a);
        logic [7:0] res;
        res = 8'h00;
        unique case (sel)
            3'b000: res = a << 5;
            3'b001: res = a << 2;
            3'b010: res = a >> 3;
            3'b011: res = a >> 4;
            3'b100: res = {a[6:0], a[7]};
            3'b101: res = {a[3:0], a[7:4]};
            3'b110: res = a << 3;
            3'b111: res = a >> 6;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_id_q, out_id_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic slot_free;
    logic grant0, grant1;
    logic accept0, accept1;
    logic deliver;

    assign slot_free = !out_valid_q || out_ready;

    // Lone requester always wins; on contention the priority pointer decides.
    assign grant0 = req0_valid && (!req1_valid || !prio_q);
    assign grant1 = req1_valid && (!req0_valid || prio_q);

    assign req0_ready = slot_free && grant0;
    assign req1_ready = slot_free && grant1;

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;
    assign deliver = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        prio_d      = prio_q;
        if (accept0) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_op(req0_sel, req0_data);
            out_id_d    = 1'b0;
            prio_d      = 1'b1;
        end else if (accept1) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_op(req1_sel, req1_data);
            out_id_d    = 1'b1;
            prio_d      = 1'b0;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear has priority over a same-cycle delivery increment.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (cnt_clr) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else if (deliver) begin
            if (!out_id_q && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
            if (out_id_q && (cnt1_q != '1))  cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_id_q    <= 1'b0;
            prio_q      <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            prio_q      <= prio_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign done_cnt0 = cnt0_q;
    assign done_cnt1 = cnt1_q;

endmodule
